// File: rtl/usb_token_rx.sv
// Receive-side USB token decoder: parses OUT/IN/SETUP/SOF, checks the PID complement and CRC5.
// Optional address filter: define USB_TOKEN_ADDR_FILTER_EN to drop OUT/IN/SETUP tokens not addressed to dev_addr.
//
// state   | meaning
// IDLE    | waiting for rx_active rising edge
// PID     | expecting the PID byte
// F1      | expecting field byte 1
// F2      | expecting field byte 2 (field MSBs + CRC5)
// EOP     | three bytes received, waiting for rx_active to fall
// DISCARD | ignoring rest of packet until rx_active falls
module usb_token_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  input  logic [6:0]  dev_addr,
  output logic        tok_valid,
  output logic [3:0]  tok_pid,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_endp,
  output logic        sof_valid,
  output logic [10:0] frame_num,
  output logic        crc_err,
  output logic        pid_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_F1, S_F2, S_EOP, S_DISCARD
  } state_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  state_t      state, state_nxt;
  logic        rx_active_q;
  logic [3:0]  pid_q, pid_nxt;
  logic [7:0]  byte1_q, byte1_nxt;
  logic [7:0]  byte2_q, byte2_nxt;
  logic        pid_bad_q, pid_bad_nxt;
  logic        tok_valid_nxt, sof_valid_nxt, crc_err_nxt, pid_err_nxt;
  logic [10:0] field;
  logic [4:0]  crc_reg;
  logic [4:0]  crc_exp;
  logic        crc_ok;
  logic        addr_ok;
  logic        is_token_pid;

  function automatic logic [4:0] crc5(input logic [10:0] d);
    logic [4:0] c;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  assign field   = {byte2_q[2:0], byte1_q};
  assign crc_reg = crc5(field);
  // CRC MSB goes first on the wire, so it lands in byte2[3]
  assign crc_exp = ~{crc_reg[0], crc_reg[1], crc_reg[2], crc_reg[3], crc_reg[4]};
  assign crc_ok  = (byte2_q[7:3] == crc_exp);

  assign is_token_pid = (rx_data[3:0] == PID_OUT) || (rx_data[3:0] == PID_IN) ||
                        (rx_data[3:0] == PID_SOF) || (rx_data[3:0] == PID_SETUP);

`ifdef USB_TOKEN_ADDR_FILTER_EN
  assign addr_ok = (field[6:0] == dev_addr);
`else
  logic unused_dev_addr;
  assign unused_dev_addr = ^dev_addr;
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    state_nxt     = state;
    pid_nxt       = pid_q;
    byte1_nxt     = byte1_q;
    byte2_nxt     = byte2_q;
    pid_bad_nxt   = pid_bad_q;
    tok_valid_nxt = 1'b0;
    sof_valid_nxt = 1'b0;
    crc_err_nxt   = 1'b0;
    pid_err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        pid_bad_nxt = 1'b0;
        if (rx_active && !rx_active_q) state_nxt = S_PID;
      end
      S_PID: begin
        if (rx_error) state_nxt = rx_active ? S_DISCARD : S_IDLE;
        else if (!rx_active) state_nxt = S_IDLE;
        else if (rx_valid) begin
          if (rx_data[7:4] != ~rx_data[3:0]) begin
            pid_bad_nxt = 1'b1;
            state_nxt   = S_DISCARD;
          end else if (is_token_pid) begin
            pid_nxt   = rx_data[3:0];
            state_nxt = S_F1;
          end else begin
            state_nxt = S_DISCARD;
          end
        end
      end
      S_F1: begin
        if (rx_error) state_nxt = rx_active ? S_DISCARD : S_IDLE;
        else if (!rx_active) state_nxt = S_IDLE;
        else if (rx_valid) begin
          byte1_nxt = rx_data;
          state_nxt = S_F2;
        end
      end
      S_F2: begin
        if (rx_error) state_nxt = rx_active ? S_DISCARD : S_IDLE;
        else if (!rx_active) state_nxt = S_IDLE;
        else if (rx_valid) begin
          byte2_nxt = rx_data;
          state_nxt = S_EOP;
        end
      end
      S_EOP: begin
        if (rx_error) state_nxt = rx_active ? S_DISCARD : S_IDLE;
        else if (!rx_active) begin
          state_nxt = S_IDLE;
          if (!crc_ok)               crc_err_nxt   = 1'b1;
          else if (pid_q == PID_SOF) sof_valid_nxt = 1'b1;
          else if (addr_ok)          tok_valid_nxt = 1'b1;
        end else if (rx_valid) state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        if (rx_error) pid_bad_nxt = 1'b0;
        if (!rx_active) begin
          state_nxt = S_IDLE;
          if (pid_bad_q && !rx_error) pid_err_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // rx_active_q resets high so a packet already in flight is not seen as a new rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rx_active_q <= 1'b1;
      pid_q       <= 4'd0;
      byte1_q     <= 8'd0;
      byte2_q     <= 8'd0;
      pid_bad_q   <= 1'b0;
      tok_valid   <= 1'b0;
      sof_valid   <= 1'b0;
      crc_err     <= 1'b0;
      pid_err     <= 1'b0;
      tok_pid     <= 4'd0;
      tok_addr    <= 7'd0;
      tok_endp    <= 4'd0;
      frame_num   <= 11'd0;
    end else begin
      state       <= state_nxt;
      rx_active_q <= rx_active;
      pid_q       <= pid_nxt;
      byte1_q     <= byte1_nxt;
      byte2_q     <= byte2_nxt;
      pid_bad_q   <= pid_bad_nxt;
      tok_valid   <= tok_valid_nxt;
      sof_valid   <= sof_valid_nxt;
      crc_err     <= crc_err_nxt;
      pid_err     <= pid_err_nxt;
      if (tok_valid_nxt) begin
        tok_pid  <= pid_q;
        tok_addr <= field[6:0];
        tok_endp <= field[10:7];
      end
      if (sof_valid_nxt) frame_num <= field;
    end
  end

endmodule

// File: tb/tb_usb_token_rx.sv
// Directed bench for usb_token_rx; expected CRC bytes were worked out by hand from the CRC5 definition.
module tb_usb_token_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_active = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_error = 1'b0;
  logic [6:0]  dev_addr = 7'd5;
  logic        tok_valid;
  logic [3:0]  tok_pid;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic        sof_valid;
  logic [10:0] frame_num;
  logic        crc_err;
  logic        pid_err;

  int total = 0;
  int bad = 0;

  usb_token_rx dut (
    .clk(clk), .rst(rst), .rx_active(rx_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_error(rx_error), .dev_addr(dev_addr),
    .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_addr(tok_addr),
    .tok_endp(tok_endp), .sof_valid(sof_valid), .frame_num(frame_num),
    .crc_err(crc_err), .pid_err(pid_err)
  );

  always #5 clk = ~clk;

  // strobes packed as {tok_valid, sof_valid, crc_err, pid_err}
  task automatic grab(output logic [3:0] s);
    @(posedge clk); #2;
    s = {tok_valid, sof_valid, crc_err, pid_err};
  endtask

  task automatic grab_window(output logic [3:0] s);
    logic [3:0] t;
    s = 4'b0;
    for (int i = 0; i < 3; i++) begin
      grab(t);
      s = s | t;
    end
  endtask

  // rx_active rises one cycle before the first byte; bytes spaced by an idle cycle
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input int n);
    @(posedge clk); #1 rx_active = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = (i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : b3;
      @(posedge clk); #1 rx_valid = 1'b0;
    end
    rx_active = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] s;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    grab(s);
    total++; if (s !== 4'b0000) begin bad++; $display("FAIL reset_strobes got=%b want=0000", s); end
    total++; if ({tok_pid, tok_addr, tok_endp, frame_num} !== 26'd0) begin
      bad++; $display("FAIL reset_fields got pid=%h addr=%h endp=%h frame=%h want 0",
                      tok_pid, tok_addr, tok_endp, frame_num);
    end
  endtask

  task automatic test_setup;
    logic [3:0] s;
    send_pkt(8'h2D, 8'h00, 8'h10, 8'h00, 3);
    grab(s);
    total++; if (s !== 4'b1000) begin bad++; $display("FAIL setup_strobe got=%b want=1000", s); end
    total++; if ({tok_pid, tok_addr, tok_endp} !== {4'hD, 7'h00, 4'h0}) begin
      bad++; $display("FAIL setup_fields got pid=%h addr=%h endp=%h want D/00/0", tok_pid, tok_addr, tok_endp);
    end
    grab(s);
    total++; if (s !== 4'b0000) begin bad++; $display("FAIL setup_one_cycle got=%b want=0000", s); end
  endtask

  task automatic test_in_crc;
    logic [3:0] s;
    // addr 0x15, endp 0xE: byte1 = {endp[0], addr}, byte2 = {crc, endp[3:1]}
    send_pkt(8'h69, 8'h15, 8'hEF, 8'h00, 3);
    grab(s);
    total++; if (s !== 4'b1000) begin bad++; $display("FAIL in_strobe got=%b want=1000", s); end
    total++; if ({tok_pid, tok_addr, tok_endp} !== {4'h9, 7'h15, 4'hE}) begin
      bad++; $display("FAIL in_fields got pid=%h addr=%h endp=%h want 9/15/E", tok_pid, tok_addr, tok_endp);
    end
    grab(s);
    send_pkt(8'h69, 8'h15, 8'h6F, 8'h00, 3);
    grab(s);
    total++; if (s !== 4'b0010) begin bad++; $display("FAIL in_crc_err got=%b want=0010", s); end
    grab(s);
    total++; if ({tok_pid, tok_addr, tok_endp} !== {4'h9, 7'h15, 4'hE}) begin
      bad++; $display("FAIL crc_err_hold got pid=%h addr=%h endp=%h want 9/15/E", tok_pid, tok_addr, tok_endp);
    end
  endtask

  task automatic test_pid;
    logic [3:0] s;
    send_pkt(8'h2C, 8'h00, 8'h10, 8'h00, 3);
    grab(s);
    total++; if (s !== 4'b0001) begin bad++; $display("FAIL pid_err got=%b want=0001", s); end
    grab(s);
    send_pkt(8'hC3, 8'h11, 8'h22, 8'h33, 4);
    grab_window(s);
    total++; if (s !== 4'b0000) begin bad++; $display("FAIL data0_silent got=%b want=0000", s); end
    send_pkt(8'h2D, 8'h00, 8'h00, 8'h00, 2);
    grab_window(s);
    total++; if (s !== 4'b0000) begin bad++; $display("FAIL short_pkt got=%b want=0000", s); end
  endtask

  task automatic test_sof;
    logic [3:0] s;
    send_pkt(8'hA5, 8'hFF, 8'h47, 8'h00, 3);
    grab(s);
    total++; if (s !== 4'b0100) begin bad++; $display("FAIL sof_strobe got=%b want=0100", s); end
    total++; if (frame_num !== 11'h7FF) begin bad++; $display("FAIL sof_frame got=%h want=7ff", frame_num); end
    grab(s);
    send_pkt(8'hA5, 8'h00, 8'h10, 8'h00, 4);
    grab_window(s);
    total++; if (s !== 4'b0000) begin bad++; $display("FAIL sof_long got=%b want=0000", s); end
    total++; if (frame_num !== 11'h7FF) begin bad++; $display("FAIL sof_hold got=%h want=7ff", frame_num); end
  endtask

  task automatic test_error_recovery;
    logic [3:0] s;
    @(posedge clk); #1 rx_active = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h69;
    @(posedge clk); #1 rx_valid = 1'b0; rx_error = 1'b1;
    @(posedge clk); #1 rx_error = 1'b0; rx_valid = 1'b1; rx_data = 8'h15;
    @(posedge clk); #1 rx_data = 8'hEF;
    @(posedge clk); #1 rx_valid = 1'b0; rx_active = 1'b0;
    grab_window(s);
    total++; if (s !== 4'b0000) begin bad++; $display("FAIL rx_error_drop got=%b want=0000", s); end

    @(posedge clk); #1 rx_active = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h2D;
    @(posedge clk); #1 rx_data = 8'h00;
    @(posedge clk); #1 rx_valid = 1'b0; rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h10;
    @(posedge clk); #1 rx_valid = 1'b0; rx_active = 1'b0;
    grab_window(s);
    total++; if (s !== 4'b0000) begin bad++; $display("FAIL rst_mid_drop got=%b want=0000", s); end
    total++; if (tok_pid !== 4'h0) begin bad++; $display("FAIL rst_mid_clear got=%h want=0", tok_pid); end

    send_pkt(8'h2D, 8'h00, 8'h10, 8'h00, 3);
    grab(s);
    total++; if ({s, tok_pid, tok_addr} !== {4'b1000, 4'hD, 7'h00}) begin
      bad++; $display("FAIL recover_setup got strobes=%b pid=%h addr=%h want 1000/D/00", s, tok_pid, tok_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] s;
    send_pkt(8'h2D, 8'h05, 8'hD0, 8'h00, 3);
    grab(s);
    total++; if ({s, tok_addr} !== {4'b1000, 7'h05}) begin
      bad++; $display("FAIL b2b_setup got strobes=%b addr=%h want 1000/05", s, tok_addr);
    end
    send_pkt(8'hA5, 8'hFF, 8'h47, 8'h00, 3);
    grab(s);
    total++; if ({s, frame_num} !== {4'b0100, 11'h7FF}) begin
      bad++; $display("FAIL b2b_sof got strobes=%b frame=%h want 0100/7ff", s, frame_num);
    end
    grab(s);
  endtask

  task automatic test_addr_filter;
    logic [3:0] s;
    send_pkt(8'h2D, 8'h00, 8'h10, 8'h00, 3);
`ifdef USB_TOKEN_ADDR_FILTER_EN
    grab_window(s);
    total++; if (s !== 4'b0000) begin bad++; $display("FAIL filter_drop got=%b want=0000", s); end
    total++; if (tok_addr !== 7'h05) begin bad++; $display("FAIL filter_hold got=%h want=05", tok_addr); end
    send_pkt(8'h2D, 8'h05, 8'hD0, 8'h00, 3);
    grab(s);
    total++; if ({s, tok_addr} !== {4'b1000, 7'h05}) begin
      bad++; $display("FAIL filter_match got strobes=%b addr=%h want 1000/05", s, tok_addr);
    end
`else
    grab(s);
    total++; if ({s, tok_addr} !== {4'b1000, 7'h00}) begin
      bad++; $display("FAIL nofilter_pass got strobes=%b addr=%h want 1000/00", s, tok_addr);
    end
`endif
    grab(s);
  endtask

  initial begin
    test_reset;
    test_setup;
    test_in_crc;
    test_pid;
    test_sof;
    test_error_recovery;
    test_back_to_back;
    test_addr_filter;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
